// File: rtl/bsg_gateway_reset_seq.sv
// Staged reset sequencer behind the gateway clock generator.
// Optional lock watchdog: define BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN.
module bsg_gateway_reset_seq #(
  parameter int num_stages_p         = 3,
  parameter int sync_stages_p        = 2,
  parameter int lock_stable_cycles_p = 1024,
  parameter int stage_gap_cycles_p   = 64,
  parameter int loss_cnt_width_p     = 8,
  parameter int watchdog_cycles_p    = 65536
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        locked_i,
  input  logic                        sw_reset_i,
  output logic [num_stages_p-1:0]     reset_o,
  output logic                        done_o,
  output logic [1:0]                  state_o,
  output logic [loss_cnt_width_p-1:0] lock_loss_cnt_o,
  output logic                        lock_timeout_o
);

  localparam int MaxLg = (lock_stable_cycles_p > stage_gap_cycles_p)
                       ? lock_stable_cycles_p : stage_gap_cycles_p;
  localparam int CntW  = (MaxLg > 1) ? $clog2(MaxLg) : 1;
  localparam int IdxW  = (num_stages_p > 1) ? $clog2(num_stages_p) : 1;

  localparam logic [CntW-1:0] LastL   = CntW'(lock_stable_cycles_p - 1);
  localparam logic [CntW-1:0] LastG   = CntW'(stage_gap_cycles_p - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(num_stages_p - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_STABLE  = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_e;

  logic [sync_stages_p-1:0]    sync_q, sync_d;
  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [num_stages_p-1:0]     rst_q, rst_d;
  logic                        done_q, done_d;
  logic [loss_cnt_width_p-1:0] loss_q, loss_d;
  logic                        lock_s;
  logic                        abort;

  assign lock_s = sync_q[sync_stages_p-1];
  assign abort  = (state_q != S_WAIT) && (!lock_s || sw_reset_i);

  always_comb begin
    sync_d  = {sync_q[sync_stages_p-2:0], locked_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    loss_d  = loss_q;
    if (abort) begin
      state_d = S_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      // sw reset alone is not a lock loss
      if (!lock_s && (loss_q != '1))
        loss_d = loss_q + 1'b1;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          rst_d  = '1;
          done_d = 1'b0;
          if (lock_s && !sw_reset_i) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end
        end
        S_STABLE: begin
          if (cnt_q == LastL) begin
            state_d  = S_RELEASE;
            cnt_d    = '0;
            idx_d    = '0;
            rst_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == LastG) begin
            cnt_d = '0;
            if (idx_q == LastIdx) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
              for (int k = 0; k < num_stages_p; k++)
                if (k == int'(idx_q) + 1)
                  rst_d[k] = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          rst_d  = '0;
          done_d = 1'b1;
        end
        default: begin
          state_d = S_WAIT;
          rst_d   = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q  <= '0;
      state_q <= S_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  assign reset_o         = rst_q;
  assign done_o          = done_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

`ifdef BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN
  localparam int WdW = (watchdog_cycles_p > 1) ? $clog2(watchdog_cycles_p) : 1;
  localparam logic [WdW-1:0] LastWd = WdW'(watchdog_cycles_p - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           to_q, to_d;

  always_comb begin
    wd_d = '0;
    to_d = to_q;
    if (state_q == S_WAIT) begin
      if (wd_q == LastWd) begin
        wd_d = wd_q;
        to_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign lock_timeout_o = to_q;
`else
  // watchdog parameter stays in the port map so both builds share it
  assign lock_timeout_o = 1'b0 && (watchdog_cycles_p != 0);
`endif

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Scoreboard bench for bsg_gateway_reset_seq: timeline model vs DUT.
module tb_bsg_gateway_reset_seq;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int L  = 16;
  localparam int G  = 4;
  localparam int LW = 8;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked = 1'b0;
  logic          sw = 1'b0;
  logic [N-1:0]  reset_o;
  logic          done_o;
  logic [1:0]    state_o;
  logic [LW-1:0] loss_o;
  logic          to_o;

  bsg_gateway_reset_seq #(
    .num_stages_p(N),
    .sync_stages_p(S),
    .lock_stable_cycles_p(L),
    .stage_gap_cycles_p(G),
    .loss_cnt_width_p(LW),
    .watchdog_cycles_p(W)
  ) u_dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .locked_i(locked),
    .sw_reset_i(sw),
    .reset_o(reset_o),
    .done_o(done_o),
    .state_o(state_o),
    .lock_loss_cnt_o(loss_o),
    .lock_timeout_o(to_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  r;
    logic          d;
    logic [1:0]    st;
    logic [LW-1:0] loss;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef BSG_GATEWAY_RESET_SEQ_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: a sequence is a start edge; outputs follow from elapsed edges.
  logic [S-1:0] m_pipe;
  bit           m_act;
  int           m_t0, m_edge, m_loss, m_wc;
  bit           m_to;

  initial begin
    logic ls;
    int   e;
    exp_t x;
    m_edge = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pipe = '0;
        m_act  = 0;
        m_loss = 0;
        m_wc   = 0;
        m_to   = 0;
        m_t0   = 0;
      end else begin
        ls = m_pipe[S-1];
        m_pipe = {m_pipe[S-2:0], locked};
        if (m_act) begin
          m_wc = 0;
          if (!ls || sw) begin
            m_act = 0;
            if (!ls && m_loss < (1 << LW) - 1) m_loss++;
          end
        end else begin
          m_wc++;
          if (WD_ON && m_wc >= W) m_to = 1;
          if (ls && !sw) begin
            m_act = 1;
            m_t0  = m_edge;
          end
        end
        e = m_edge - m_t0;
        for (int k = 0; k < N; k++)
          x.r[k] = !(m_act && e >= L + k * G);
        x.d    = m_act && (e >= L + N * G);
        x.st   = !m_act ? 2'd0 : (e < L) ? 2'd1 :
                 (e < L + N * G) ? 2'd2 : 2'd3;
        x.loss = m_loss[LW-1:0];
        x.to   = m_to;
        sb.push_back(x);
        m_edge++;
      end
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("reset_o", 32'(reset_o), 32'(x.r));
        check("done_o", 32'(done_o), 32'(x.d));
        check("state_o", 32'(state_o), 32'(x.st));
        check("lock_loss_cnt_o", 32'(loss_o), 32'(x.loss));
        check("lock_timeout_o", 32'(to_o), 32'(x.to));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_reset_o"}, 32'(reset_o), 32'h7);
    check({tag, "_done_o"}, 32'(done_o), 0);
    check({tag, "_state_o"}, 32'(state_o), 0);
    check({tag, "_loss"}, 32'(loss_o), 0);
    check({tag, "_timeout"}, 32'(to_o), 0);
  endtask

  initial begin
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // lock absent long enough for the watchdog
    cyc(40);
    check("watchdog_flag", 32'(to_o), 32'(WD_ON));

    // clean bring-up
    locked = 1'b1;
    cyc(35);
    check("bringup_done", 32'(done_o), 1);
    check("bringup_state", 32'(state_o), 3);
    check("watchdog_sticky", 32'(to_o), 32'(WD_ON));

    // software reset in RUN
    sw = 1'b1;
    cyc(1);
    sw = 1'b0;
    check("swrst_reset_o", 32'(reset_o), 32'h7);
    check("swrst_loss", 32'(loss_o), 0);
    cyc(35);
    check("swrst_redone", 32'(done_o), 1);

    // lock loss in RUN
    locked = 1'b0;
    cyc(4);
    check("runloss_reset_o", 32'(reset_o), 32'h7);
    check("runloss_cnt", 32'(loss_o), 1);

    // one-cycle glitch while STABLE counts ten
    locked = 1'b1;
    cyc(11);
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    cyc(3);
    check("glitch_cnt", 32'(loss_o), 2);
    check("glitch_reset_o", 32'(reset_o), 32'h7);
    cyc(35);
    check("glitch_redone", 32'(done_o), 1);

    // random lock drops and software resets
    for (int i = 0; i < 1500; i++) begin
      if (locked && $urandom_range(0, 99) < 2) locked = 1'b0;
      else if (!locked && $urandom_range(0, 99) < 40) locked = 1'b1;
      sw = ($urandom_range(0, 99) < 2);
      cyc(1);
    end
    sw = 1'b0;
    locked = 1'b1;
    cyc(40);

    // saturate the loss counter
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1;
      cyc(4);
      locked = 1'b0;
      cyc(3);
    end
    check("loss_saturated", 32'(loss_o), 255);

    // async reset in the middle of RELEASE
    locked = 1'b1;
    cyc(22);
    check("midrel_state", 32'(state_o), 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrel");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(35);
    check("post_reset_done", 32'(done_o), 1);
    check("post_reset_loss", 32'(loss_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
